// File: rtl/blob_centroid.sv
// blob_centroid: accumulates per-label area and coordinate sums over a frame,
// then picks the largest eligible blob and divides its sums into a centroid.
module blob_centroid #(
  parameter int unsigned HRES       = 1280,
  parameter int unsigned VRES       = 720,
  parameter int unsigned MAX_LABELS = 64,
  parameter int unsigned MIN_AREA   = 10
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] label_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        valid_in,
  output logic [10:0] centroid_x_out,
  output logic [9:0]  centroid_y_out,
  output logic [19:0] area_out,
  output logic [15:0] blob_label_out,
  output logic        found_out,
  output logic        result_valid_out,
  output logic        overflow_out,
  output logic        busy_out
);

  localparam int unsigned LW = $clog2(MAX_LABELS);
  localparam int unsigned AW = 20;
  localparam int unsigned SW = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_ACCUM,
    S_SCAN,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [LW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;

  logic [AW-1:0]   r_area  [MAX_LABELS];
  logic [SW-1:0]   r_sum_x [MAX_LABELS];
  logic [SW-1:0]   r_sum_y [MAX_LABELS];

  logic [AW-1:0]   r_best_area;
  logic [SW-1:0]   r_best_sx;
  logic [SW-1:0]   r_best_sy;
  logic [LW-1:0]   r_best_idx;
  logic            r_found;

  // Dividend registers become the quotients as bits shift in from the right
  logic [SW-1:0]   r_qx;
  logic [SW-1:0]   r_qy;
  logic [AW-1:0]   r_rx;
  logic [AW-1:0]   r_ry;

  logic [LW-1:0]   w_lbl;
  logic            w_in_range;
  logic            w_eof_pix;
  logic            w_last_idx;
  logic            w_take;
  logic            w_acc;
  logic            w_ovf_pix;
  logic            w_eof;
  logic [AW-1:0]   w_slot_area;
  logic [SW-1:0]   w_slot_sx;
  logic [SW-1:0]   w_slot_sy;
  logic [AW:0]     w_div;
  logic [AW:0]     w_px;
  logic [AW:0]     w_py;
  logic            w_gx;
  logic            w_gy;

  assign w_lbl       = label_in[LW-1:0];
  assign w_in_range  = (label_in < 16'(MAX_LABELS));
  assign w_eof_pix   = (hcount_in == 11'(HRES - 1)) && (vcount_in == 10'(VRES - 1));
  assign w_last_idx  = (r_idx == LW'(MAX_LABELS - 1));
  assign w_slot_area = r_area[r_idx];
  assign w_slot_sx   = r_sum_x[r_idx];
  assign w_slot_sy   = r_sum_y[r_idx];
  // Strict greater-than keeps the lowest label on equal areas
  assign w_take      = (w_slot_area >= AW'(MIN_AREA)) && (w_slot_area > r_best_area);

  // Restoring divider step: shift in next dividend bit, subtract if it fits
  assign w_div = {1'b0, r_best_area};
  assign w_px  = {r_rx, r_qx[SW-1]};
  assign w_py  = {r_ry, r_qy[SW-1]};
  assign w_gx  = (w_px >= w_div);
  assign w_gy  = (w_py >= w_div);

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-pixel strobes
  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    w_ovf_pix   = 1'b0;
    w_eof       = 1'b0;
    case (r_state)
      S_CLEAR: begin
        if (w_last_idx) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (valid_in) begin
          w_acc     = (label_in != 16'd0) && w_in_range;
          w_ovf_pix = !w_in_range;
          if (w_eof_pix) begin
            w_eof       = 1'b1;
            w_state_nxt = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (w_last_idx) w_state_nxt = (r_found || w_take) ? S_DIVIDE : S_DONE;
      end
      S_DIVIDE: begin
        if (r_cnt == CW'(SW - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_ACCUM;
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // Slot storage: zeroed while clearing or as each slot is scanned, else RMW accumulate
  always_ff @(posedge clk_in) begin
    if ((r_state == S_CLEAR) || (r_state == S_SCAN)) begin
      r_area[r_idx]  <= '0;
      r_sum_x[r_idx] <= '0;
      r_sum_y[r_idx] <= '0;
    end else if (w_acc) begin
      r_area[w_lbl]  <= r_area[w_lbl] + AW'(1);
      r_sum_x[w_lbl] <= r_sum_x[w_lbl] + SW'(hcount_in);
      r_sum_y[w_lbl] <= r_sum_y[w_lbl] + SW'(vcount_in);
    end
  end

  // Scan selection, division and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_idx            <= '0;
      r_cnt            <= '0;
      r_best_area      <= '0;
      r_best_sx        <= '0;
      r_best_sy        <= '0;
      r_best_idx       <= '0;
      r_found          <= 1'b0;
      r_qx             <= '0;
      r_qy             <= '0;
      r_rx             <= '0;
      r_ry             <= '0;
      centroid_x_out   <= '0;
      centroid_y_out   <= '0;
      area_out         <= '0;
      blob_label_out   <= '0;
      found_out        <= 1'b0;
      result_valid_out <= 1'b0;
      overflow_out     <= 1'b0;
      busy_out         <= 1'b1;
    end else begin
      result_valid_out <= 1'b0;
      busy_out         <= (w_state_nxt != S_ACCUM);
      // Sticky per frame; held through the result pulse, then cleared
      overflow_out     <= (overflow_out && !result_valid_out) || w_ovf_pix;
      case (r_state)
        S_CLEAR: begin
          r_idx <= r_idx + LW'(1);
        end
        S_ACCUM: begin
          if (w_eof) begin
            r_idx       <= LW'(1);
            r_best_area <= '0;
            r_best_sx   <= '0;
            r_best_sy   <= '0;
            r_best_idx  <= '0;
            r_found     <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_take) begin
            r_best_area <= w_slot_area;
            r_best_sx   <= w_slot_sx;
            r_best_sy   <= w_slot_sy;
            r_best_idx  <= r_idx;
            r_found     <= 1'b1;
          end
          r_idx <= r_idx + LW'(1);
          r_cnt <= '0;
          r_rx  <= '0;
          r_ry  <= '0;
          r_qx  <= w_take ? w_slot_sx : r_best_sx;
          r_qy  <= w_take ? w_slot_sy : r_best_sy;
        end
        S_DIVIDE: begin
          r_cnt <= r_cnt + CW'(1);
          r_rx  <= w_gx ? AW'(w_px - w_div) : AW'(w_px);
          r_ry  <= w_gy ? AW'(w_py - w_div) : AW'(w_py);
          r_qx  <= {r_qx[SW-2:0], w_gx};
          r_qy  <= {r_qy[SW-2:0], w_gy};
        end
        S_DONE: begin
          result_valid_out <= 1'b1;
          found_out        <= r_found;
          if (r_found) begin
            centroid_x_out <= r_qx[10:0];
            centroid_y_out <= r_qy[9:0];
            area_out       <= r_best_area;
            blob_label_out <= 16'(r_best_idx);
          end else begin
            centroid_x_out <= '0;
            centroid_y_out <= '0;
            area_out       <= '0;
            blob_label_out <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
